led_matrix_scanner: RTL and testbench

- Parametrised successor to the 8x8 LED matrix column driver: shifts frame data in serially, double-buffers it, and scans the matrix one column at a time.
- Strobe is synchronised and edge-detected in the clk domain; it is never used as a clock.
- Buffer swap happens only at a frame boundary, so the display never shows a torn frame.
- Adds a programmable column dwell (prescaler) and blanking dead-time between columns.

---
 rtl/led_matrix_scanner.sv | 159 +++++++++++++++
 tb/tb_led_matrix_scanner.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// LED matrix scanner: serial shift chain, double-buffered frame, column scan.
// Optional row PWM gating: define LED_MATRIX_BRIGHTNESS_PWM_EN.
module led_matrix_scanner #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int PRESCALE_W   = 8,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  ser_data,
  input  logic                  shift_en,
  input  logic                  strobe,
  input  logic [PRESCALE_W-1:0] prescale,
`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
  input  logic [PRESCALE_W-1:0] brightness,
`endif
  output logic [ROWS-1:0]       row_out,
  output logic [COLS-1:0]       col_sel,
  output logic                  frame_start,
  output logic                  latch_pending
);

  localparam int N  = ROWS * COLS;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [3:0] BL_LAST = 4'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DISPLAY, BLANK} state_t;

  state_t                state_q, state_n;
  logic [CW-1:0]         col_q, col_n;
  logic [PRESCALE_W-1:0] cnt_q, cnt_n;
  logic [PRESCALE_W-1:0] pre_q, pre_n;
  logic [3:0]            bcnt_q, bcnt_n;
  logic [N-1:0]          chain_q, chain_n;
  logic [N-1:0]          vbuf_q, vbuf_n;
  logic [2:0]            sync_q;
  logic                  pend_n;
  logic                  enter, swap, rise;
  logic [ROWS-1:0]       row_n;
  logic [COLS-1:0]       col_sel_n;
`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
  logic [PRESCALE_W-1:0] bri_q, bri_n;
`endif

  always_comb begin
    state_n = state_q;
    col_n   = col_q;
    cnt_n   = cnt_q;
    pre_n   = pre_q;
    bcnt_n  = bcnt_q;
    enter   = 1'b0;
    if (!ena) begin
      state_n = IDLE;
      col_n   = '0;
      cnt_n   = '0;
      bcnt_n  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_n = DISPLAY;
          col_n   = '0;
          cnt_n   = '0;
          enter   = 1'b1;
        end
        DISPLAY: begin
          if (cnt_q == pre_q) begin
            cnt_n = '0;
            if (BLANK_CYCLES == 0) begin
              state_n = DISPLAY;
              enter   = 1'b1;
              col_n   = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
            end else begin
              state_n = BLANK;
              bcnt_n  = '0;
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        BLANK: begin
          if (bcnt_q == BL_LAST) begin
            state_n = DISPLAY;
            enter   = 1'b1;
            cnt_n   = '0;
            col_n   = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
          end else begin
            bcnt_n = bcnt_q + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (enter) pre_n = prescale;
  end

  // Swap only at the frame boundary (column 0 entry) or while idle
  assign rise    = sync_q[1] & ~sync_q[2];
  assign swap    = latch_pending &
                   ((state_q == IDLE) || (enter && col_n == '0));
  assign pend_n  = swap ? 1'b0 : (latch_pending | rise);
  assign vbuf_n  = swap ? chain_q : vbuf_q;
  assign chain_n = shift_en ? {chain_q[N-2:0], ser_data} : chain_q;

`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
  assign bri_n = enter ? brightness : bri_q;
`endif

  always_comb begin
    row_n     = '0;
    col_sel_n = '0;
    if (state_n == DISPLAY) begin
      col_sel_n = COLS'(1) << col_n;
      for (int c = 0; c < COLS; c++)
        if (col_n == CW'(c)) row_n = vbuf_n[c*ROWS +: ROWS];
`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
      if (cnt_n >= bri_n) row_n = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      col_q         <= '0;
      cnt_q         <= '0;
      pre_q         <= '0;
      bcnt_q        <= '0;
      chain_q       <= '0;
      vbuf_q        <= '0;
      sync_q        <= '0;
      latch_pending <= 1'b0;
      row_out       <= '0;
      col_sel       <= '0;
      frame_start   <= 1'b0;
`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
      bri_q         <= '0;
`endif
    end else begin
      state_q       <= state_n;
      col_q         <= col_n;
      cnt_q         <= cnt_n;
      pre_q         <= pre_n;
      bcnt_q        <= bcnt_n;
      chain_q       <= chain_n;
      vbuf_q        <= vbuf_n;
      sync_q        <= {sync_q[1:0], strobe};
      latch_pending <= pend_n;
      row_out       <= row_n;
      col_sel       <= col_sel_n;
      frame_start   <= enter && (col_n == '0);
`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
      bri_q         <= bri_n;
`endif
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner (default parameters, prescale=3).
// Covers scan timing, swap at frame wrap, strobe absorb, ena drop, reset.
module tb_led_matrix_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       ser_data = 1'b0;
  logic       shift_en = 1'b0;
  logic       strobe = 1'b0;
  logic [7:0] prescale = 8'd3;
  logic [7:0] row_out;
  logic [7:0] col_sel;
  logic       frame_start;
  logic       latch_pending;
`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
  logic [7:0] brightness = 8'hff;
`endif

  int tests = 0;
  int fails = 0;
  int k = 0;
  logic [63:0] frame = '0;

  localparam logic [63:0] PAT1 = 64'h8040201008040201;
  localparam logic [63:0] PAT2 = 64'h0102040810204080;
  localparam logic [63:0] PAT3 = 64'h1122334455667788;

  led_matrix_scanner dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .ser_data(ser_data),
    .shift_en(shift_en),
    .strobe(strobe),
    .prescale(prescale),
`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
    .brightness(brightness),
`endif
    .row_out(row_out),
    .col_sel(col_sel),
    .frame_start(frame_start),
    .latch_pending(latch_pending)
  );

  always #5 clk = ~clk;

  // k = cycles since DISPLAY of column 0 began; 40-cycle frame
  function automatic logic [7:0] exp_col(int kk);
    int p = kk % 40;
    if (p % 5 < 4) return 8'(1 << (p / 5));
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_row(int kk, logic [63:0] f);
    int p = kk % 40;
    if (p % 5 < 4) return f[(p/5)*8 +: 8];
    return 8'h00;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic start_scan;
    rst_n = 1'b0;
    ena = 1'b0;
    tick;
    rst_n = 1'b1;
    ena = 1'b1;
    tick;
    k = 0;
  endtask

  task automatic shift_word(input logic [63:0] w);
    for (int i = 63; i >= 0; i--) begin
      shift_en = 1'b1;
      ser_data = w[i];
      tick;
      tests++;
      if (row_out !== exp_row(k, frame)) begin
        fails++;
        $display("FAIL shift_row k=%0d got %h want %h",
                 k, row_out, exp_row(k, frame));
      end
    end
    shift_en = 1'b0;
    ser_data = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    tests++;
    if ({row_out, col_sel, frame_start, latch_pending} !== 18'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h/%h/%b/%b want 0",
               row_out, col_sel, frame_start, latch_pending);
    end
  endtask

  task automatic test_scan;
    start_scan;
    frame = '0;
    for (int i = 0; i < 81; i++) begin
      tests++;
      if (col_sel !== exp_col(k) || frame_start !== (k % 40 == 0) ||
          row_out !== 8'h00) begin
        fails++;
        $display("FAIL scan k=%0d col %h want %h fs %b",
                 k, col_sel, exp_col(k), frame_start);
      end
      if (i < 80) tick;
    end
  endtask

  task automatic test_swap;
    start_scan;
    frame = '0;
    shift_word(PAT1);
    strobe = 1'b1;
    tick;
    strobe = 1'b0;
    tick;
    tests++;
    if (latch_pending !== 1'b0) begin
      fails++;
      $display("FAIL pend_early got %b want 0", latch_pending);
    end
    tick;
    tests++;
    if (latch_pending !== 1'b1) begin
      fails++;
      $display("FAIL pend_3clk got %b want 1", latch_pending);
    end
    while (k < 79) begin
      tick;
      tests++;
      if (row_out !== exp_row(k, frame)) begin
        fails++;
        $display("FAIL pre_wrap_row k=%0d got %h want %h",
                 k, row_out, exp_row(k, frame));
      end
    end
    tick;
    frame = PAT1;
    tests++;
    if (frame_start !== 1'b1 || latch_pending !== 1'b0 ||
        row_out !== 8'h01) begin
      fails++;
      $display("FAIL wrap_swap fs %b pend %b row %h want 1/0/01",
               frame_start, latch_pending, row_out);
    end
    while (k < 120) begin
      tick;
      tests++;
      if (row_out !== exp_row(k, frame) || col_sel !== exp_col(k)) begin
        fails++;
        $display("FAIL new_frame k=%0d row %h want %h",
                 k, row_out, exp_row(k, frame));
      end
    end
  endtask

  task automatic test_noswap;
    for (int i = 0; i < 120; i++) begin
      shift_en = 1'($urandom);
      ser_data = 1'($urandom);
      tick;
      tests++;
      if (row_out !== exp_row(k, frame) ||
          frame_start !== (k % 40 == 0)) begin
        fails++;
        $display("FAIL noswap k=%0d row %h want %h",
                 k, row_out, exp_row(k, frame));
      end
    end
    shift_en = 1'b0;
  endtask

  task automatic test_double_strobe;
    shift_word(PAT2);
    while (k % 40 != 2) tick;
    strobe = 1'b1;
    tick;
    strobe = 1'b0;
    tick;
    tick;
    strobe = 1'b1;
    tick;
    strobe = 1'b0;
    while (k % 40 != 39) tick;
    tests++;
    if (latch_pending !== 1'b1 || row_out !== exp_row(k, frame)) begin
      fails++;
      $display("FAIL double_pre pend %b row %h", latch_pending, row_out);
    end
    tick;
    frame = PAT2;
    tests++;
    if (row_out !== 8'h80 || latch_pending !== 1'b0) begin
      fails++;
      $display("FAIL double_wrap row %h pend %b want 80/0",
               row_out, latch_pending);
    end
    for (int i = 0; i < 41; i++) begin
      tick;
      tests++;
      if (latch_pending !== 1'b0 || row_out !== exp_row(k, frame)) begin
        fails++;
        $display("FAIL double_after k=%0d pend %b row %h want %h",
                 k, latch_pending, row_out, exp_row(k, frame));
      end
    end
  endtask

  task automatic test_ena_drop;
    shift_word(PAT3);
    while (k % 40 != 15) tick;
    strobe = 1'b1;
    tick;
    strobe = 1'b0;
    tick;
    tick;
    tests++;
    if (latch_pending !== 1'b1) begin
      fails++;
      $display("FAIL drop_pend got %b want 1", latch_pending);
    end
    while (k % 40 != 26) tick;
    ena = 1'b0;
    tick;
    tests++;
    if (row_out !== 8'h00 || col_sel !== 8'h00 ||
        frame_start !== 1'b0 || latch_pending !== 1'b1) begin
      fails++;
      $display("FAIL drop_idle row %h col %h fs %b pend %b",
               row_out, col_sel, frame_start, latch_pending);
    end
    tick;
    tests++;
    if (latch_pending !== 1'b0) begin
      fails++;
      $display("FAIL idle_swap pend %b want 0", latch_pending);
    end
    ena = 1'b1;
    tick;
    k = 0;
    frame = PAT3;
    tests++;
    if (frame_start !== 1'b1 || col_sel !== 8'h01 || row_out !== 8'h88) begin
      fails++;
      $display("FAIL restart fs %b col %h row %h want 1/01/88",
               frame_start, col_sel, row_out);
    end
    while (k < 10) begin
      tick;
      tests++;
      if (row_out !== exp_row(k, frame) || col_sel !== exp_col(k)) begin
        fails++;
        $display("FAIL restart_scan k=%0d row %h want %h",
                 k, row_out, exp_row(k, frame));
      end
    end
  endtask

  task automatic test_reset_blank;
    while (k < 19) tick;
    rst_n = 1'b0;
    tick;
    tests++;
    if ({row_out, col_sel, frame_start, latch_pending} !== 18'd0) begin
      fails++;
      $display("FAIL reset_blank got %h/%h/%b/%b want 0",
               row_out, col_sel, frame_start, latch_pending);
    end
    rst_n = 1'b1;
    tick;
    k = 0;
    frame = '0;
    for (int i = 0; i < 40; i++) begin
      tests++;
      if (row_out !== 8'h00 || col_sel !== exp_col(k)) begin
        fails++;
        $display("FAIL vbuf_cleared k=%0d row %h col %h", k, row_out, col_sel);
      end
      tick;
    end
    ena = 1'b0;
    strobe = 1'b1;
    tick;
    strobe = 1'b0;
    repeat (5) tick;
    ena = 1'b1;
    tick;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      tests++;
      if (row_out !== 8'h00) begin
        fails++;
        $display("FAIL chain_cleared k=%0d row %h want 00", k, row_out);
      end
      tick;
    end
  endtask

`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
  task automatic test_pwm;
    logic [7:0] want;
    rst_n = 1'b0;
    ena = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      shift_en = 1'b1;
      ser_data = 1'b1;
      tick;
    end
    shift_en = 1'b0;
    strobe = 1'b1;
    tick;
    strobe = 1'b0;
    repeat (5) tick;
    brightness = 8'd2;
    ena = 1'b1;
    tick;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      want = (k % 5 < 2) ? 8'hff : 8'h00;
      tests++;
      if (row_out !== want || col_sel !== exp_col(k)) begin
        fails++;
        $display("FAIL pwm k=%0d row %h want %h col %h",
                 k, row_out, want, col_sel);
      end
      tick;
    end
    brightness = 8'hff;
  endtask
`endif

  initial begin
    test_reset;
    test_scan;
    test_swap;
    test_noswap;
    test_double_strobe;
    test_ena_drop;
    test_reset_blank;
`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
    test_pwm;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
